clk_div: RTL and testbench

- Programmable integer clock divider, posedge-only, registered output.
- Generates the slow clock that feeds a downstream glitch-free clock mux input; clk_i is the fast source clock.
- Divide ratio changes through a valid/ready handshake and take effect only at an output-period boundary, so clk_o never produces a runt pulse.

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_req.sv | 39 +++
 rtl/clk_div.sv | 116 +++++++++++
 tb/tb_clk_div.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// The RUN/PARK state type is only used when CLK_DIV_GATE_EN is defined.
package clk_div_pkg;

  localparam int DIV_MIN = 2;

  typedef enum logic {
    RUN,
    PARK
  } clk_div_state_e;

  // High-phase length of an N-cycle output period; odd ratios get the extra cycle high.
  function automatic logic [31:0] hi_len(input logic [31:0] n);
    return (n + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_req.sv
// Pending divide-ratio register with valid/ready handshake and sticky error flag.
// Illegal ratios are accepted but discarded.
module clk_div_req
  import clk_div_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic [DIV_W-1:0] div,
  input  logic             valid,
  input  logic             apply,
  output logic             ready,
  output logic             pend_vld,
  output logic [DIV_W-1:0] pend_div,
  output logic             err
);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      pend_vld <= 1'b0;
      pend_div <= '0;
      err      <= 1'b0;
    end else if (valid && !pend_vld) begin
      if (div >= DIV_W'(DIV_MIN)) begin
        pend_vld <= 1'b1;
        pend_div <= div;
        err      <= 1'b0;
      end else begin
        err <= 1'b1;
      end
    end else if (apply) begin
      pend_vld <= 1'b0;
    end
  end

  assign ready = !pend_vld;

endmodule

// File: rtl/clk_div.sv
// Programmable integer clock divider; ratio changes land only on period boundaries.
// Optional run/park gating is enabled by defining CLK_DIV_GATE_EN.
module clk_div
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_valid_i,
`ifdef CLK_DIV_GATE_EN
  input  logic             en_i,
  output logic             stopped_o,
`endif
  output logic             div_ready_o,
  output logic             err_o,
  output logic [DIV_W-1:0] ratio_o,
  output logic             tick_o,
  output logic             clk_o
);

  if (DEF_DIV < DIV_MIN || DEF_DIV >= (2 ** DIV_W)) begin : g_def_div_chk
    $error("clk_div: DEF_DIV out of range");
  end

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_nxt;
  logic [DIV_W-1:0] ratio_q, ratio_nxt;
  logic             clk_q, clk_nxt;
  logic             tick_q, tick_nxt;
  logic             boundary, apply;
  logic             pend_vld;
  logic [DIV_W-1:0] pend_div;

`ifdef CLK_DIV_GATE_EN
  // state | meaning
  // RUN   | counting, clk_o toggling
  // PARK  | stopped at a boundary, clk_o held low
  clk_div_state_e state_q, state_nxt;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) state_q <= RUN;
    else          state_q <= state_nxt;
  end

  assign stopped_o = (state_q == PARK);
`endif

  always_comb begin
    boundary  = (cnt_q == ratio_q - ONE);
    apply     = boundary;
    cnt_nxt   = boundary ? '0 : cnt_q + ONE;
    ratio_nxt = (boundary && pend_vld) ? pend_div : ratio_q;
    clk_nxt   = ({1'b0, cnt_nxt} < (DIV_W + 1)'(hi_len(32'(ratio_nxt))));
    tick_nxt  = (cnt_nxt == '0);
`ifdef CLK_DIV_GATE_EN
    state_nxt = state_q;
    case (state_q)
      RUN: begin
        if (boundary && !en_i) begin
          state_nxt = PARK;
          cnt_nxt   = '0;
          clk_nxt   = 1'b0;
          tick_nxt  = 1'b0;
        end
      end
      PARK: begin
        // Pending ratio may load on any parked cycle; restart begins a full period.
        apply     = 1'b1;
        ratio_nxt = pend_vld ? pend_div : ratio_q;
        cnt_nxt   = '0;
        clk_nxt   = en_i;
        tick_nxt  = en_i;
        if (en_i) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
`endif
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      cnt_q   <= '0;
      ratio_q <= DIV_W'(DEF_DIV);
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_nxt;
      ratio_q <= ratio_nxt;
      clk_q   <= clk_nxt;
      tick_q  <= tick_nxt;
    end
  end

  clk_div_req #(
    .DIV_W(DIV_W)
  ) u_req (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .div     (div_i),
    .valid   (div_valid_i),
    .apply   (apply),
    .ready   (div_ready_o),
    .pend_vld(pend_vld),
    .pend_div(pend_div),
    .err     (err_o)
  );

  assign ratio_o = ratio_q;
  assign tick_o  = tick_q;
  assign clk_o   = clk_q;

endmodule

// File: tb/tb_clk_div.sv
// Self-checking bench for clk_div: table of ratio requests with a scoreboard queue,
// plus hand sequences for back-to-back requests, mid-period reset and (optionally) park.
module tb_clk_div;

  logic       clk_i = 1'b0;
  logic       arst_ni = 1'b0;
  logic [7:0] div_i = 8'd0;
  logic       div_valid_i = 1'b0;
  logic       div_ready_o, err_o, tick_o, clk_o;
  logic [7:0] ratio_o;
`ifdef CLK_DIV_GATE_EN
  logic       en_i = 1'b1;
  logic       stopped_o;
`endif

  clk_div #(.DIV_W(8), .DEF_DIV(2)) dut (
    .clk_i      (clk_i),
    .arst_ni    (arst_ni),
    .div_i      (div_i),
    .div_valid_i(div_valid_i),
`ifdef CLK_DIV_GATE_EN
    .en_i       (en_i),
    .stopped_o  (stopped_o),
`endif
    .div_ready_o(div_ready_o),
    .err_o      (err_o),
    .ratio_o    (ratio_o),
    .tick_o     (tick_o),
    .clk_o      (clk_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] div;
    bit         err;
    int         ratio;
    int         hi;
    int         lo;
  } vec_t;

  vec_t tbl[10];
  vec_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!div_ready_o && k < 400) begin step(); k++; end
    check("ready_wait_timeout", int'(div_ready_o), 1);
  endtask

  task automatic wait_tick();
    int k = 0;
    while (!tick_o && k < 400) begin step(); k++; end
    check("tick_wait_timeout", int'(tick_o), 1);
  endtask

  // Starts on a sample inside the high phase; ends on the next tick sample.
  task automatic measure(input int hi0, output int hi, output int lo);
    int k = 0;
    hi = hi0;
    lo = 0;
    while (clk_o && k < 400) begin hi++; step(); k++; end
    while (!tick_o && k < 800) begin
      if (!clk_o) lo++;
      step(); k++;
    end
  endtask

  task automatic send(input logic [7:0] d, input bit hold);
    wait_ready();
    div_i = d;
    div_valid_i = 1'b1;
    step();
    if (!hold) div_valid_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    int hi, lo;
    send(v.div, 1'b0);
    sb.push_back(v);
    e = sb.pop_front();
    if (e.err) begin
      check("illegal_err", int'(err_o), 1);
      check("illegal_ready", int'(div_ready_o), 1);
      check("illegal_ratio", int'(ratio_o), e.ratio);
      wait_tick();
    end else begin
      check("accept_ready_low", int'(div_ready_o), 0);
      check("accept_err_clear", int'(err_o), 0);
      wait_ready();
      check("apply_ratio", int'(ratio_o), e.ratio);
      check("apply_tick", int'(tick_o), 1);
    end
    measure(0, hi, lo);
    check("period_hi", hi, e.hi);
    check("period_lo", lo, e.lo);
  endtask

  task automatic post_reset_run(input string tag);
    for (int e = 1; e <= 6; e++) begin
      step();
      check({tag, "_clk"}, int'(clk_o), int'(e % 2 == 0));
      check({tag, "_tick"}, int'(tick_o), int'(e % 2 == 0));
      check({tag, "_ratio"}, int'(ratio_o), 2);
    end
  endtask

  initial begin
    vec_t e;
    int hi, lo, k;

    tbl[0] = '{8'd5,   1'b0, 5,   3,   2};
    tbl[1] = '{8'd1,   1'b1, 5,   3,   2};
    tbl[2] = '{8'd4,   1'b0, 4,   2,   2};
    tbl[3] = '{8'd0,   1'b1, 4,   2,   2};
    tbl[4] = '{8'd3,   1'b0, 3,   2,   1};
    tbl[5] = '{8'd3,   1'b0, 3,   2,   1};
    tbl[6] = '{8'd7,   1'b0, 7,   4,   3};
    tbl[7] = '{8'd2,   1'b0, 2,   1,   1};
    tbl[8] = '{8'd255, 1'b0, 255, 128, 127};
    tbl[9] = '{8'd6,   1'b0, 6,   3,   3};

    step();
    step();
    check("rst_clk", int'(clk_o), 0);
    check("rst_tick", int'(tick_o), 0);
    check("rst_ready", int'(div_ready_o), 1);
    check("rst_err", int'(err_o), 0);
    check("rst_ratio", int'(ratio_o), 2);
`ifdef CLK_DIV_GATE_EN
    check("rst_stopped", int'(stopped_o), 0);
`endif
    arst_ni = 1'b1;
    post_reset_run("def");

    for (int i = 0; i < 10; i++) run_vec(tbl[i]);

    // Back-to-back: N=7 stalls until N=3 has been applied.
    sb.push_back('{8'd3, 1'b0, 3, 2, 1});
    sb.push_back('{8'd7, 1'b0, 7, 4, 3});
    send(8'd3, 1'b1);
    check("b2b_first_ready", int'(div_ready_o), 0);
    div_i = 8'd7;
    step();
    check("b2b_stall_ready", int'(div_ready_o), 0);
    wait_ready();
    e = sb.pop_front();
    check("b2b_first_ratio", int'(ratio_o), e.ratio);
    check("b2b_first_tick", int'(tick_o), 1);
    check("b2b_first_clk", int'(clk_o), 1);
    step();
    check("b2b_second_accept", int'(div_ready_o), 0);
    check("b2b_hi_cont", int'(clk_o), 1);
    div_valid_i = 1'b0;
    measure(1, hi, lo);
    check("b2b_first_hi", hi, e.hi);
    check("b2b_first_lo", lo, e.lo);
    e = sb.pop_front();
    check("b2b_second_ratio", int'(ratio_o), e.ratio);
    check("b2b_second_ready", int'(div_ready_o), 1);
    measure(0, hi, lo);
    check("b2b_second_hi", hi, e.hi);
    check("b2b_second_lo", lo, e.lo);

    // Async reset in the high phase at N=6 with a request pending.
    run_vec('{8'd6, 1'b0, 6, 3, 3});
    step();
    div_i = 8'd4;
    div_valid_i = 1'b1;
    step();
    div_valid_i = 1'b0;
    check("mid_pend_ready", int'(div_ready_o), 0);
    check("mid_high", int'(clk_o), 1);
    #2 arst_ni = 1'b0;
    #1;
    check("arst_clk", int'(clk_o), 0);
    check("arst_tick", int'(tick_o), 0);
    check("arst_ratio", int'(ratio_o), 2);
    check("arst_ready", int'(div_ready_o), 1);
    step();
    arst_ni = 1'b1;
    post_reset_run("rst2");
    check("rst2_pend_lost", int'(div_ready_o), 1);

`ifdef CLK_DIV_GATE_EN
    run_vec('{8'd4, 1'b0, 4, 2, 2});
    step();
    check("gate_cnt1_clk", int'(clk_o), 1);
    en_i = 1'b0;
    k = 0;
    while (!stopped_o && k < 20) begin step(); k++; end
    check("gate_park_latency", k, 3);
    check("gate_park_clk", int'(clk_o), 0);
    check("gate_park_tick", int'(tick_o), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("gate_parked_clk", int'(clk_o), 0);
      check("gate_parked_stopped", int'(stopped_o), 1);
    end
    en_i = 1'b1;
    step();
    check("gate_resume_clk", int'(clk_o), 1);
    check("gate_resume_tick", int'(tick_o), 1);
    check("gate_resume_stopped", int'(stopped_o), 0);
    measure(0, hi, lo);
    check("gate_resume_hi", hi, 2);
    check("gate_resume_lo", lo, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
